// File: rtl/sm_regwr_arb_pkg.sv
// Shared defaults, limits and types for the register-file write arbiter.
package sm_regwr_arb_pkg;

  localparam int unsigned P_NREQS_DEF      = 4;
  localparam int unsigned P_ADDR_NBITS_DEF = 5;
  localparam int unsigned P_DATA_NBITS_DEF = 32;
  localparam int unsigned P_MAX_NREQS      = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_e;

  function automatic int unsigned f_idx_nbits(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sm_regwr_arb_if.sv
// Requester and register-file write-port signals of sm_regwr_arb.
interface sm_regwr_arb_if
  import sm_regwr_arb_pkg::*;
#(
  parameter int unsigned p_nreqs      = P_NREQS_DEF,
  parameter int unsigned p_addr_nbits = P_ADDR_NBITS_DEF,
  parameter int unsigned p_data_nbits = P_DATA_NBITS_DEF,
  parameter int unsigned p_idx_nbits  = f_idx_nbits(p_nreqs)
);
  logic [p_nreqs-1:0]              req_val;
  logic [p_nreqs-1:0]              req_rdy;
  logic [p_nreqs*p_addr_nbits-1:0] req_addr;
  logic [p_nreqs*p_data_nbits-1:0] req_data;
  logic                            wr_stall;
  logic                            wr_en;
  logic [p_addr_nbits-1:0]         wr_addr;
  logic [p_data_nbits-1:0]         wr_data;
  logic [p_idx_nbits-1:0]          grant_idx;

  modport master (
    output req_val, req_addr, req_data, wr_stall,
    input  req_rdy, wr_en, wr_addr, wr_data, grant_idx
  );

  modport slave (
    input  req_val, req_addr, req_data, wr_stall,
    output req_rdy, wr_en, wr_addr, wr_data, grant_idx
  );
endinterface

// File: rtl/sm_reg_rst.sv
// Enabled register with synchronous active-high reset to a fixed value.
module sm_reg_rst #(
  parameter int unsigned          p_nbits   = 1,
  parameter logic [p_nbits-1:0]   p_rst_val = '0
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [p_nbits-1:0] i_d,
  output logic [p_nbits-1:0] o_q
);
  always_ff @(posedge clk) begin
    if (i_rst)     o_q <= p_rst_val;
    else if (i_en) o_q <= i_d;
  end
endmodule

// File: rtl/sm_rr_arb.sv
// Round-robin grant: first asserted request at or after i_ptr, wrapping.
module sm_rr_arb
  import sm_regwr_arb_pkg::*;
#(
  parameter int unsigned p_nreqs     = P_NREQS_DEF,
  parameter int unsigned p_idx_nbits = f_idx_nbits(p_nreqs)
) (
  input  logic [p_nreqs-1:0]     i_req,
  input  logic [p_idx_nbits-1:0] i_ptr,
  input  logic                   i_en,
  output logic [p_nreqs-1:0]     o_grant,
  output logic [p_idx_nbits-1:0] o_grant_idx
);
  always_comb begin : search
    logic        found;
    int unsigned pos;
    o_grant     = '0;
    o_grant_idx = '0;
    found       = 1'b0;
    pos         = 0;
    // Rotated scan expressed with loop indices only, so every select is constant.
    for (int unsigned k = 0; k < p_nreqs; k++) begin
      pos = 32'(i_ptr) + k;
      if (pos >= p_nreqs) pos = pos - p_nreqs;
      for (int unsigned i = 0; i < p_nreqs; i++) begin
        if (i_en && !found && (pos == i) && i_req[i]) begin
          found          = 1'b1;
          o_grant[i]     = 1'b1;
          o_grant_idx    = p_idx_nbits'(i);
        end
      end
    end
  end
endmodule

// File: rtl/sm_regwr_arb.sv
// Round-robin arbiter sharing one register-file write port among p_nreqs requesters.
// Define SM_REGWR_ARB_PIPE_EN to add a registered output stage (latency 1).
module sm_regwr_arb
  import sm_regwr_arb_pkg::*;
#(
  parameter int unsigned p_nreqs      = P_NREQS_DEF,
  parameter int unsigned p_addr_nbits = P_ADDR_NBITS_DEF,
  parameter int unsigned p_data_nbits = P_DATA_NBITS_DEF
) (
  input  logic          clk,
  input  logic          reset,
  sm_regwr_arb_if.slave bus
);
  localparam int unsigned IW = f_idx_nbits(p_nreqs);

  logic                    w_rst;
  logic                    w_en;
  logic                    w_xfer;
  logic [p_nreqs-1:0]      w_grant;
  logic [IW-1:0]           w_gidx;
  logic [IW-1:0]           r_ptr;
  logic [IW-1:0]           w_ptr_nxt;
  logic [p_addr_nbits-1:0] w_sel_addr;
  logic [p_data_nbits-1:0] w_sel_data;

  assign w_rst = ~reset;

  sm_rr_arb #(.p_nreqs(p_nreqs), .p_idx_nbits(IW)) u_arb (
    .i_req       (bus.req_val),
    .i_ptr       (r_ptr),
    .i_en        (w_en),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx)
  );

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int unsigned i = 0; i < p_nreqs; i++) begin
      if (w_grant[i]) begin
        w_sel_addr = bus.req_addr[i*p_addr_nbits +: p_addr_nbits];
        w_sel_data = bus.req_data[i*p_data_nbits +: p_data_nbits];
      end
    end
  end

  assign w_xfer      = |w_grant;
  assign w_ptr_nxt   = (w_gidx == IW'(p_nreqs - 1)) ? '0 : w_gidx + IW'(1);
  assign bus.req_rdy = w_grant;

  sm_reg_rst #(.p_nbits(IW)) u_ptr (
    .clk   (clk),
    .i_rst (w_rst),
    .i_en  (w_xfer),
    .i_d   (w_ptr_nxt),
    .o_q   (r_ptr)
  );

`ifdef SM_REGWR_ARB_PIPE_EN
  localparam int unsigned OW = p_addr_nbits + p_data_nbits + IW;

  stage_e        w_stage;
  stage_e        w_stage_nxt;
  logic          r_stage;
  logic          w_ld;
  logic [OW-1:0] r_out;

  assign w_stage = stage_e'(r_stage);
  assign w_en    = reset & ((w_stage == ST_EMPTY) | ~bus.wr_stall);

  always_comb begin
    w_stage_nxt = w_stage;
    w_ld        = 1'b0;
    unique case (w_stage)
      ST_EMPTY: begin
        if (w_xfer) begin
          w_stage_nxt = ST_FULL;
          w_ld        = 1'b1;
        end
      end
      ST_FULL: begin
        if (!bus.wr_stall) begin
          w_stage_nxt = w_xfer ? ST_FULL : ST_EMPTY;
          w_ld        = 1'b1;
        end
      end
      default: w_stage_nxt = ST_EMPTY;
    endcase
  end

  sm_reg_rst #(.p_nbits(1)) u_stage (
    .clk   (clk),
    .i_rst (w_rst),
    .i_en  (1'b1),
    .i_d   (w_stage_nxt),
    .o_q   (r_stage)
  );

  // Draining without a refill clears the payload so an idle port reads zero.
  sm_reg_rst #(.p_nbits(OW)) u_out (
    .clk   (clk),
    .i_rst (w_rst),
    .i_en  (w_ld),
    .i_d   (w_xfer ? {w_sel_addr, w_sel_data, w_gidx} : '0),
    .o_q   (r_out)
  );

  assign bus.wr_en = (w_stage == ST_FULL);
  assign {bus.wr_addr, bus.wr_data, bus.grant_idx} = r_out;
`else
  assign w_en          = reset & ~bus.wr_stall;
  assign bus.wr_en     = w_xfer;
  assign bus.wr_addr   = w_sel_addr;
  assign bus.wr_data   = w_sel_data;
  assign bus.grant_idx = w_gidx;
`endif

endmodule

// File: doc/sm_regwr_arb.md
SM_REGWR_ARB -- requirements
Module: sm_regwr_arb

Interface
REQ-001 Parameter p_nreqs, default 4, SHALL set the number of requesters sharing the register-file write port; legal range 2..16.
REQ-002 Parameter p_addr_nbits, default 5, SHALL set the register address width.
REQ-003 Parameter p_data_nbits, default 32, SHALL set the write data width.
REQ-004 clk  input  1  SHALL be the clock; all state updates on the posedge.
REQ-005 reset  input  1  SHALL be the reset: synchronous, active-low.
REQ-006 req_val  input  p_nreqs  SHALL carry the per-requester write-request valid bits.
REQ-007 req_rdy  output  p_nreqs  SHALL be the per-requester accept bits; at most one bit is high per cycle.
REQ-008 req_addr  input  p_nreqs*p_addr_nbits  SHALL carry the packed addresses; requester i occupies bits [i*A +: A].
REQ-009 req_data  input  p_nreqs*p_data_nbits  SHALL carry the packed data; requester i occupies bits [i*D +: D].
REQ-010 wr_stall  input  1  SHALL indicate that the register-file write port cannot accept a write this cycle.
REQ-011 wr_en  output  1  SHALL be the register-file write enable.
REQ-012 wr_addr  output  p_addr_nbits  SHALL be the register-file write address.
REQ-013 wr_data  output  p_data_nbits  SHALL be the register-file write data.
REQ-014 grant_idx  output  $clog2(p_nreqs)  SHALL give the index of the requester whose write is on wr_*; it is 0 when wr_en=0.

Function
REQ-015 A transfer from requester i SHALL occur on the cycle where req_val[i] & req_rdy[i] are both high.
REQ-016 req_rdy SHALL depend combinationally on req_val, wr_stall and internal state; req_val SHALL NOT be required to wait for req_rdy.
REQ-017 Arbitration SHALL be round-robin: the search starts at priority pointer ptr and wraps modulo p_nreqs, and the first valid requester is granted.
REQ-018 After a transfer from requester i, ptr SHALL become (i+1) mod p_nreqs; with no transfer, ptr SHALL hold.
REQ-019 Index p_nreqs-1 SHALL wrap to 0 (e.g., grant 3 with N=4 -> ptr=0).
REQ-020 With no valid requester, req_rdy SHALL be all-zero and wr_en SHALL be 0; wr_addr and wr_data SHALL then be 0.
REQ-021 When the block is able to accept (REQ-027 / REQ-029), exactly one req_rdy bit SHALL be high if any req_val bit is high; a granted requester SHALL NOT be starved beyond p_nreqs-1 other transfers.
REQ-022 If a requester drops req_val without a transfer, it SHALL lose the grant with no state change.

Reset
REQ-023 While reset=0 at a posedge: ptr SHALL be set to 0, any pipeline stage SHALL be emptied, and req_rdy SHALL be 0.
REQ-024 Reset outputs SHALL be wr_en=0, wr_addr=0, wr_data=0, grant_idx=0.
REQ-025 Reset SHALL override all other events, including an in-flight stalled write, which is discarded.
REQ-026 The first cycle with reset=1 SHALL arbitrate from requester 0.

Configuration
REQ-027 Without SM_REGWR_ARB_PIPE_EN:
- the path is combinational, latency 0;
- wr_en = any transfer;
- req_rdy is all-zero while wr_stall=1.
REQ-028 With SM_REGWR_ARB_PIPE_EN, a single output register stage SHALL be added: wr_* and grant_idx are registered, and write latency is 1 cycle.
REQ-029 Pipelined stage rules (SM_REGWR_ARB_PIPE_EN):
- the stage accepts when empty or when (full & !wr_stall);
- a simultaneous drain and fill SHALL sustain 1 write/cycle;
- while full and wr_stall=1, wr_* SHALL hold stable and req_rdy=0.

Structure
REQ-030 Package sm_regwr_arb_pkg SHALL hold the parameter defaults, the max-requester constant (16), and a helper function for the index width.
REQ-031 Round-robin grant logic SHALL be a sub-module sm_rr_arb: inputs req, ptr, en; outputs one-hot grant and grant index.
REQ-032 ptr and the pipeline stage SHALL use the team reset-register components with active-low adaptation at instantiation.

Verification
REQ-033 The bench SHALL cover: reset=0 for 2 cycles, then req_val=4'b1111 with stall=0 -> grants 0,1,2,3,0 on consecutive cycles; wr_addr follows each requester.
REQ-034 The bench SHALL cover: ptr=3 and req_val=4'b1001 -> grant 3, then grant 0 (wrap).
REQ-035 The bench SHALL cover: wr_stall=1 for 3 cycles with req_val=4'b0100, non-pipelined -> req_rdy=0 and wr_en=0; on release -> grant 2 in the same cycle.
REQ-036 The bench SHALL cover: under PIPE_EN, a write (addr=5, data=0xDEAD_BEEF) -> wr_en is high the next cycle; with stall=1, the values hold for 2 cycles, then drain while accepting the next request (back-to-back).
REQ-037 The bench SHALL cover: reset=0 asserted while a stalled write is held -> next cycle wr_en=0 and ptr=0.
REQ-038 The bench SHALL cover: random val/stall for 10k cycles against a reference model -> no lost or duplicated writes, at most one req_rdy bit high, and every requester is served within p_nreqs transfers.
